// File: rtl/wtm_4bit_20bee0082.sv
// Unsigned 4x4 Wallace-tree multiplier, registered 8-bit product.
// Two HA/FA reduction layers feed a ripple carry-propagate adder.
module wtm_4bit_20bee0082_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module wtm_4bit_20bee0082_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

module wtm_4bit_20bee0082 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] P
);
  logic [3:0][3:0] pp;
  logic [7:0]      prod;

  // pp[i][j] has weight i+j
  always_comb begin
    pp = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = a[j] & b[i];
      end
    end
  end

  // layer 1: heights 1,2,3,4,3,2,1 -> 1,2,1,3,2,3,1
  logic s1_2, c1_2;
  logic s1_3, c1_3;
  logic s1_4, c1_4;

  wtm_4bit_20bee0082_fa u_l1_c2 (
    .x(pp[0][2]), .y(pp[1][1]), .z(pp[2][0]),
    .s(s1_2), .c(c1_2)
  );
  wtm_4bit_20bee0082_fa u_l1_c3 (
    .x(pp[0][3]), .y(pp[1][2]), .z(pp[2][1]),
    .s(s1_3), .c(c1_3)
  );
  wtm_4bit_20bee0082_fa u_l1_c4 (
    .x(pp[1][3]), .y(pp[2][2]), .z(pp[3][1]),
    .s(s1_4), .c(c1_4)
  );

  // layer 2: -> every column at most 2 high
  logic s2_3, c2_3;
  logic s2_4, c2_4;
  logic s2_5, c2_5;

  wtm_4bit_20bee0082_fa u_l2_c3 (
    .x(c1_2), .y(s1_3), .z(pp[3][0]),
    .s(s2_3), .c(c2_3)
  );
  wtm_4bit_20bee0082_ha u_l2_c4 (
    .x(c1_3), .y(s1_4),
    .s(s2_4), .c(c2_4)
  );
  wtm_4bit_20bee0082_fa u_l2_c5 (
    .x(c1_4), .y(pp[2][3]), .z(pp[3][2]),
    .s(s2_5), .c(c2_5)
  );

  // ripple carry-propagate adder over the two remaining rows
  logic r1, r2, r3, r4, r5, r6;

  assign prod[0] = pp[0][0];

  wtm_4bit_20bee0082_ha u_r1 (
    .x(pp[0][1]), .y(pp[1][0]),
    .s(prod[1]), .c(r1)
  );
  wtm_4bit_20bee0082_ha u_r2 (
    .x(s1_2), .y(r1),
    .s(prod[2]), .c(r2)
  );
  wtm_4bit_20bee0082_ha u_r3 (
    .x(s2_3), .y(r2),
    .s(prod[3]), .c(r3)
  );
  wtm_4bit_20bee0082_fa u_r4 (
    .x(s2_4), .y(c2_3), .z(r3),
    .s(prod[4]), .c(r4)
  );
  wtm_4bit_20bee0082_fa u_r5 (
    .x(s2_5), .y(c2_4), .z(r4),
    .s(prod[5]), .c(r5)
  );
  wtm_4bit_20bee0082_fa u_r6 (
    .x(pp[3][3]), .y(c2_5), .z(r5),
    .s(prod[6]), .c(r6)
  );

  assign prod[7] = r6;

  always_ff @(posedge clk) begin
    if (rst) P <= 8'h00;
    else     P <= prod;
  end
endmodule

// File: tb/tb_wtm_4bit_20bee0082.sv
// Directed bench for wtm_4bit_20bee0082.
// Drives on falling edges, samples one falling edge later.
module tb_wtm_4bit_20bee0082;
  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] P;

  int checks;
  int failures;

  wtm_4bit_20bee0082 dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .P(P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    a = 4'd9;
    b = 4'd7;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (P !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold%0d got=%0d exp=0", k, P);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (P !== 8'd63) begin
      failures++;
      $display("FAIL reset_release got=%0d exp=63", P);
    end
  endtask

  task automatic test_boundary();
    a = 4'd15; b = 4'd15;
    @(negedge clk);
    checks++;
    if (P !== 8'hE1) begin
      failures++;
      $display("FAIL max_15x15 got=%0d exp=225", P);
    end
    a = 4'd0; b = 4'd13;
    @(negedge clk);
    checks++;
    if (P !== 8'd0) begin
      failures++;
      $display("FAIL zero_a got=%0d exp=0", P);
    end
    a = 4'd1; b = 4'd11;
    @(negedge clk);
    checks++;
    if (P !== 8'd11) begin
      failures++;
      $display("FAIL one_a got=%0d exp=11", P);
    end
    a = 4'd14; b = 4'd0;
    @(negedge clk);
    checks++;
    if (P !== 8'd0) begin
      failures++;
      $display("FAIL zero_b got=%0d exp=0", P);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [7:0] ve [3];
    logic [7:0] prev;
    va = '{4'd13, 4'd6, 4'd8};
    vb = '{4'd11, 4'd9, 4'd8};
    ve = '{8'd143, 8'd54, 8'd64};
    prev = 8'd0;
    for (int k = 0; k < 3; k++) begin
      a = va[k];
      b = vb[k];
      #1;
      checks++;
      if (P !== prev) begin
        failures++;
        $display("FAIL b2b_early%0d got=%0d exp=%0d", k, P, prev);
      end
      @(negedge clk);
      checks++;
      if (P !== ve[k]) begin
        failures++;
        $display("FAIL b2b%0d got=%0d exp=%0d", k, P, ve[k]);
      end
      prev = ve[k];
    end
  endtask

  task automatic test_reset_mid();
    a = 4'd12; b = 4'd10;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (P !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid got=%0d exp=0", P);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (P !== 8'd120) begin
      failures++;
      $display("FAIL rst_mid_rel got=%0d exp=120", P);
    end
  endtask

  task automatic test_sweep();
    int bad;
    int exp;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      a = i[3:0];
      b = i[7:4];
      exp = (i & 15) * (i >> 4);
      @(negedge clk);
      if (P !== exp[7:0]) begin
        bad++;
        if (bad < 5)
          $display("FAIL sweep a=%0d b=%0d got=%0d exp=%0d",
                   i & 15, i >> 4, P, exp);
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL sweep_total got=%0d exp=0", bad);
    end
  endtask

  task automatic test_midcycle();
    a = 4'd3; b = 4'd5;
    @(negedge clk);
    checks++;
    if (P !== 8'd15) begin
      failures++;
      $display("FAIL mid_load got=%0d exp=15", P);
    end
    #2;
    a = 4'd7; b = 4'd7;
    #2;
    checks++;
    if (P !== 8'd15) begin
      failures++;
      $display("FAIL mid_stable got=%0d exp=15", P);
    end
    @(negedge clk);
    checks++;
    if (P !== 8'd49) begin
      failures++;
      $display("FAIL mid_next got=%0d exp=49", P);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    a = 4'd0;
    b = 4'd0;
    @(negedge clk);
    test_reset();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    test_midcycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
